// File: rtl/button_debounce.sv
// Debounces a bank of asynchronous push-buttons into the clk domain and emits
// a clean level, press/release pulses and, with BUTTON_DEBOUNCE_LONG_PRESS_EN, a long-press pulse.
module button_debounce #(
    parameter int NUM_BTN           = 2,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int INVERT            = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int               CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] INV_MASK = (INVERT != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

    logic [NUM_BTN-1:0] s1_r;
    logic [NUM_BTN-1:0] s2_r;
    logic [NUM_BTN-1:0] level_r;
    logic [NUM_BTN-1:0] rise_r;
    logic [NUM_BTN-1:0] fall_r;
    logic [CW-1:0]      cnt_r [NUM_BTN];

    // Synchronizer plus per-channel stability counter; a level is accepted only
    // after DEBOUNCE_CYCLES consecutive mismatching s2 samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= {NUM_BTN{1'b0}};
            s2_r    <= {NUM_BTN{1'b0}};
            level_r <= {NUM_BTN{1'b0}};
            rise_r  <= {NUM_BTN{1'b0}};
            fall_r  <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            s1_r <= btn_in ^ INV_MASK;
            s2_r <= s1_r;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (s2_r[i] == level_r[i]) begin
                    cnt_r[i]  <= {CW{1'b0}};
                    rise_r[i] <= 1'b0;
                    fall_r[i] <= 1'b0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    cnt_r[i]   <= {CW{1'b0}};
                    level_r[i] <= s2_r[i];
                    rise_r[i]  <= s2_r[i];
                    fall_r[i]  <= ~s2_r[i];
                end else begin
                    cnt_r[i]  <= cnt_r[i] + CW'(1);
                    rise_r[i] <= 1'b0;
                    fall_r[i] <= 1'b0;
                end
            end
        end
    end

    assign btn_level = level_r;
    assign btn_rise  = rise_r;
    assign btn_fall  = fall_r;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int            HW        = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0]      hold_r [NUM_BTN];
    logic [NUM_BTN-1:0] long_r;

    // Hold-time counter saturates, so the fire value is crossed once per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_r <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_r[i] <= {HW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                long_r[i] <= level_r[i] && (hold_r[i] == HOLD_FIRE);
                if (!level_r[i]) begin
                    hold_r[i] <= {HW{1'b0}};
                end else if (hold_r[i] != HOLD_MAX) begin
                    hold_r[i] <= hold_r[i] + HW'(1);
                end else begin
                    hold_r[i] <= hold_r[i];
                end
            end
        end
    end

    assign btn_long = long_r;
`else
    assign btn_long = {NUM_BTN{1'b0}};
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized self-checking bench for button_debounce: an active-high and an
// active-low instance are both compared every cycle against a history-window model.
module tb_button_debounce;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] btn_in_n;
    logic [NB-1:0] lvl, rise, fall, lng;
    logic [NB-1:0] i_lvl, i_rise, i_fall, i_lng;

    assign btn_in_n = ~btn_in;

    always #5 clk = ~clk;

    button_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .INVERT(0)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(lvl), .btn_rise(rise), .btn_fall(fall), .btn_long(lng)
    );

    button_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .INVERT(1)) dut_inv (
        .clk(clk), .rst(rst), .btn_in(btn_in_n),
        .btn_level(i_lvl), .btn_rise(i_rise), .btn_fall(i_fall), .btn_long(i_lng)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: pad samples delayed by two edges; a level flips once the last D
    // delayed samples all disagree with it.
    logic [NB-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall, m_long;
    logic          hist [NB][D];
    int            age [NB];
    int            edge_n = 0;
    int            first_rise [NB];
    int            first_fall [NB];
    int            first_irise0;
    int            n_rise0, n_long1;

    task automatic model_edge(input logic [NB-1:0] in, input logic r);
        logic all_diff;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        if (r) begin
            m_d1  = '0;
            m_d2  = '0;
            m_lvl = '0;
            for (int c = 0; c < NB; c++) begin
                age[c] = -1;
                for (int k = 0; k < D; k++) hist[c][k] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NB; c++) begin
                for (int k = 0; k < D - 1; k++) hist[c][k] = hist[c][k+1];
                hist[c][D-1] = m_d2[c];
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) if (hist[c][k] == m_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_rise[c] = m_lvl[c];
                    m_fall[c] = ~m_lvl[c];
                end
                if (m_rise[c]) age[c] = 0;
                else if (m_lvl[c] && age[c] >= 0) begin
                    age[c]++;
                    if (age[c] == L) m_long[c] = 1'b1;
                end
                if (!m_lvl[c]) age[c] = -1;
            end
            m_d2 = m_d1;
            m_d1 = in;
        end
    endtask

    task automatic clear_marks();
        for (int c = 0; c < NB; c++) begin
            first_rise[c] = -1;
            first_fall[c] = -1;
        end
        first_irise0 = -1;
        n_rise0 = 0;
        n_long1 = 0;
    endtask

    task automatic cycle(input logic [NB-1:0] in, input logic r);
        logic [NB-1:0] exp_long;
        @(negedge clk);
        btn_in = in;
        rst    = r;
        @(posedge clk);
        edge_n++;
        model_edge(in, r);
        #1;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        exp_long = m_long;
`else
        exp_long = '0;
`endif
        check("level", 32'(lvl), 32'(m_lvl));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
        check("long", 32'(lng), 32'(exp_long));
        check("inv_level", 32'(i_lvl), 32'(m_lvl));
        check("inv_rise", 32'(i_rise), 32'(m_rise));
        check("inv_fall", 32'(i_fall), 32'(m_fall));
        check("inv_long", 32'(i_lng), 32'(exp_long));
        for (int c = 0; c < NB; c++) begin
            if (rise[c] && first_rise[c] < 0) first_rise[c] = edge_n;
            if (fall[c] && first_fall[c] < 0) first_fall[c] = edge_n;
        end
        if (i_rise[0] && first_irise0 < 0) first_irise0 = edge_n;
        if (rise[0]) n_rise0++;
        if (lng[1]) n_long1++;
    endtask

    int            e0;
    int            left [NB];
    logic [NB-1:0] cur;

    initial begin
        model_edge('0, 1'b1);
        clear_marks();

        // Reset state
        repeat (3) cycle(2'b00, 1'b1);
        check("reset_level", 32'(lvl), 32'h0);

        // Clean press on channel 0
        clear_marks();
        e0 = edge_n + 1;
        repeat (10) cycle(2'b01, 1'b0);
        check("press_latency", 32'(first_rise[0] - e0), 32'd5);
        check("inv_press_latency", 32'(first_irise0 - e0), 32'd5);
        check("press_ch1_quiet", 32'(first_rise[1]), 32'hffff_ffff);

        // Bounce: a D-1 cycle excursion must be rejected
        repeat (8) cycle(2'b00, 1'b0);
        clear_marks();
        repeat (3) cycle(2'b01, 1'b0);
        cycle(2'b00, 1'b0);
        e0 = edge_n + 1;
        repeat (10) cycle(2'b01, 1'b0);
        check("bounce_latency", 32'(first_rise[0] - e0), 32'd5);
        check("bounce_rise_count", 32'(n_rise0), 32'd1);

        // Release ch0 and press ch1 on the same edge
        clear_marks();
        e0 = edge_n + 1;
        repeat (10) cycle(2'b10, 1'b0);
        check("release_fall0", 32'(first_fall[0] - e0), 32'd5);
        check("press_rise1", 32'(first_rise[1] - e0), 32'd5);

        // Hold ch1 for 20 more cycles
        repeat (20) cycle(2'b10, 1'b0);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        check("long_count", 32'(n_long1), 32'd1);
`else
        check("long_count", 32'(n_long1), 32'd0);
`endif

        // Reset in the middle of a qualification
        repeat (2) cycle(2'b00, 1'b1);
        clear_marks();
        repeat (4) cycle(2'b01, 1'b0);
        cycle(2'b01, 1'b1);
        check("rst_mid_level", 32'(lvl), 32'h0);
        check("rst_mid_no_rise", 32'(first_rise[0]), 32'hffff_ffff);
        clear_marks();
        e0 = edge_n + 1;
        repeat (8) cycle(2'b01, 1'b0);
        check("rst_mid_latency", 32'(first_rise[0] - e0), 32'd5);

        // Random stimulus with mixed short bounces and long holds
        cur = '0;
        for (int c = 0; c < NB; c++) left[c] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (left[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D, 4 * L))
                                                          : int'($urandom_range(1, D + 1));
                end
                left[c]--;
            end
            cycle(cur, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
